subkey_word_inject_seq: RTL and testbench

- Parametrised, registered successor to the combinational subkey word-select decode in the Threefish key-schedule path.
- Generates a one-hot per-word inject strobe for NUM_WORDS key words.
- Direct mode: injects a single selected word.
- Sweep mode: steps through a contiguous word window, one word per downstream accept.
- Sits between the round controller (start/select) and the key-word adders (valid/ready).

---
 rtl/subkey_word_inject_seq.sv | 108 ++++++++++
 tb/tb_subkey_word_inject_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/subkey_word_inject_seq.sv
// subkey_word_inject_seq: registered one-hot key-word inject sequencer (direct/sweep); optional abort via SUBKEY_INJECT_ABORT_EN
module subkey_word_inject_seq #(
  parameter int NUM_WORDS  = 16,
  parameter int SEL_W      = 4,
  parameter int FIRST_WORD = 13,
  parameter int LAST_WORD  = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [SEL_W-1:0]     select_i,
  input  logic                 control_i,
  input  logic                 ready_i,
`ifdef SUBKEY_INJECT_ABORT_EN
  input  logic                 abort_i,
`endif
  output logic [NUM_WORDS-1:0] control_o,
  output logic                 valid_o,
  output logic [SEL_W-1:0]     word_idx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIRECT = 2'd1;
  localparam logic [1:0] S_SWEEP  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [SEL_W-1:0] FIRST_IDX = SEL_W'(FIRST_WORD);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(LAST_WORD);
  localparam logic [NUM_WORDS-1:0] ONE   = {{(NUM_WORDS-1){1'b0}}, 1'b1};
  logic [1:0]           r_state, w_state_nx;
  logic [SEL_W-1:0]     r_idx, w_idx_nx;
  logic                 r_valid, w_valid_nx;
  logic                 w_done_nx, w_err_nx, w_accept, w_sel_ok, w_abort;
  logic [NUM_WORDS-1:0] w_ctrl_nx;
  assign w_accept = r_valid & ready_i;
  assign w_sel_ok = (select_i >= FIRST_IDX) && (select_i <= LAST_IDX);
`ifdef SUBKEY_INJECT_ABORT_EN
  assign w_abort = abort_i & ((r_state == S_DIRECT) | (r_state == S_SWEEP));
`else
  assign w_abort = 1'b0;
`endif
  assign w_ctrl_nx = w_valid_nx ? (ONE << w_idx_nx) : '0;
  // next-state decode; abort overrides any same-cycle accept
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_valid_nx = r_valid;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    case (r_state)
      S_IDLE:
        if (start_i & mode_i) begin
          w_state_nx = S_SWEEP;
          w_idx_nx   = FIRST_IDX;
          w_valid_nx = 1'b1;
        end else if (start_i & control_i) begin
          w_state_nx = w_sel_ok ? S_DIRECT : S_IDLE;
          w_idx_nx   = w_sel_ok ? select_i : r_idx;
          w_valid_nx = w_sel_ok;
          w_err_nx   = ~w_sel_ok;
        end
      S_DIRECT:
        if (w_accept) begin
          w_state_nx = S_DONE;
          w_valid_nx = 1'b0;
          w_done_nx  = 1'b1;
        end
      S_SWEEP:
        if (w_accept && r_idx == LAST_IDX) begin
          w_state_nx = S_DONE;
          w_valid_nx = 1'b0;
          w_done_nx  = 1'b1;
        end else if (w_accept) begin
          w_idx_nx = r_idx + 1'b1;
        end
      S_DONE:
        w_state_nx = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nx = S_IDLE;
      w_valid_nx = 1'b0;
      w_done_nx  = 1'b0;
    end
  end
  // all outputs registered so downstream adders see glitch-free strobes
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      control_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_valid    <= w_valid_nx;
      control_o  <= w_ctrl_nx;
      busy_o     <= w_state_nx != S_IDLE;
      done_o     <= w_done_nx;
      err_o      <= w_err_nx;
    end
  assign valid_o    = r_valid;
  assign word_idx_o = r_idx;
endmodule

// File: tb/tb_subkey_word_inject_seq.sv
// tb_subkey_word_inject_seq: scoreboard bench for subkey_word_inject_seq
module tb_subkey_word_inject_seq;
  logic        clk_i = 0, rst_n_i = 0, start_i = 0, mode_i = 0, control_i = 0, ready_i = 0, abort_i = 0;
  logic [3:0]  select_i = 0;
  logic [15:0] control_o;
  logic        valid_o, busy_o, done_o, err_o;
  logic [3:0]  word_idx_o;
  logic [19:0] st;
  int          checks = 0, errors = 0;
  int          q[$];
  int          e;
  assign st = {valid_o, busy_o, done_o, err_o, control_o};
  always #5 clk_i = ~clk_i;
  subkey_word_inject_seq dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .mode_i(mode_i),
    .select_i(select_i), .control_i(control_i), .ready_i(ready_i),
`ifdef SUBKEY_INJECT_ABORT_EN
    .abort_i(abort_i),
`endif
    .control_o(control_o), .valid_o(valid_o), .word_idx_o(word_idx_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o));
  always @(negedge clk_i)
    if (rst_n_i && valid_o && ready_i && !abort_i) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL accept_unexpected got idx %0d exp none", word_idx_o);
      end else begin
        e = q.pop_front();
        if (word_idx_o !== 4'(e) || control_o !== (16'h1 << e)) begin
          errors++;
          $display("FAIL accept_word got idx %0d ctrl %h exp idx %0d ctrl %h", word_idx_o, control_o, e, 16'h1 << e);
        end
      end
    end
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic q_empty(input string n);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_unconsumed got %0d exp 0", n, q.size());
    end
    q.delete();
  endtask
  task automatic test_reset();
    cyc(); cyc();
    checks++;
    if (st !== 20'h0 || word_idx_o !== 4'd0) begin errors++; $display("FAIL reset_state got %h/%0d exp 0/0", st, word_idx_o); end
    rst_n_i = 1;
    cyc();
    start_i = 1; mode_i = 1; ready_i = 1; q.push_back(13);
    cyc(); start_i = 0;
    cyc(); ready_i = 0;
    checks++;
    if (word_idx_o !== 4'd14 || control_o !== 16'h4000) begin errors++; $display("FAIL reset_pre_idx got %0d/%h exp 14/4000", word_idx_o, control_o); end
    #3 rst_n_i = 0;
    #1;
    checks++;
    if (st !== 20'h0) begin errors++; $display("FAIL reset_async got %h exp 0", st); end
    #10 rst_n_i = 1;
    cyc(); cyc();
    checks++;
    if (st !== 20'h0) begin errors++; $display("FAIL reset_idle got %h exp 0", st); end
    q_empty("reset");
  endtask
  task automatic test_direct();
    start_i = 1; mode_i = 0; control_i = 1; select_i = 14; ready_i = 1; q.push_back(14);
    cyc(); start_i = 0; control_i = 0;
    checks++;
    if (st !== {4'b1100, 16'h4000}) begin errors++; $display("FAIL direct_valid got %h exp %h", st, {4'b1100, 16'h4000}); end
    cyc();
    checks++;
    if (st !== {4'b0110, 16'h0}) begin errors++; $display("FAIL direct_done got %h exp %h", st, {4'b0110, 16'h0}); end
    cyc();
    checks++;
    if (st !== 20'h0) begin errors++; $display("FAIL direct_idle got %h exp 0", st); end
    ready_i = 0;
    q_empty("direct");
  endtask
  task automatic test_err();
    start_i = 1; mode_i = 0; control_i = 1; select_i = 5;
    cyc(); start_i = 0; control_i = 0;
    checks++;
    if (st !== {4'b0001, 16'h0}) begin errors++; $display("FAIL err_pulse got %h exp %h", st, {4'b0001, 16'h0}); end
    cyc();
    checks++;
    if (st !== 20'h0) begin errors++; $display("FAIL err_clear got %h exp 0", st); end
    start_i = 1; select_i = 14;
    cyc(); start_i = 0;
    checks++;
    if (st !== 20'h0) begin errors++; $display("FAIL ctrl_off got %h exp 0", st); end
  endtask
  task automatic test_sweep();
    start_i = 1; mode_i = 1; ready_i = 1;
    for (int i = 13; i <= 15; i++) q.push_back(i);
    cyc(); start_i = 0;
    for (int i = 13; i <= 15; i++) begin
      checks++;
      if (st !== {4'b1100, 16'h1 << i}) begin errors++; $display("FAIL sweep_word%0d got %h exp %h", i, st, {4'b1100, 16'h1 << i}); end
      cyc();
    end
    checks++;
    if (st !== {4'b0110, 16'h0}) begin errors++; $display("FAIL sweep_done got %h exp %h", st, {4'b0110, 16'h0}); end
    start_i = 1;
    cyc(); start_i = 0;
    checks++;
    if (st !== 20'h0) begin errors++; $display("FAIL done_start_ignored got %h exp 0", st); end
    ready_i = 0;
    q_empty("sweep");
  endtask
  task automatic test_backpressure();
    start_i = 1; mode_i = 1; ready_i = 0;
    for (int i = 13; i <= 15; i++) q.push_back(i);
    cyc(); start_i = 0;
    for (int h = 0; h < 4; h++) begin
      checks++;
      if (st !== {4'b1100, 16'h2000}) begin errors++; $display("FAIL hold%0d got %h exp %h", h, st, {4'b1100, 16'h2000}); end
      start_i = (h == 1); mode_i = 0; control_i = (h == 1); select_i = 15;
      ready_i = (h == 3);
      cyc();
    end
    start_i = 0; control_i = 0;
    for (int i = 14; i <= 15; i++) begin
      checks++;
      if (st !== {4'b1100, 16'h1 << i}) begin errors++; $display("FAIL bp_word%0d got %h exp %h", i, st, {4'b1100, 16'h1 << i}); end
      cyc();
    end
    checks++;
    if (st !== {4'b0110, 16'h0}) begin errors++; $display("FAIL bp_done got %h exp %h", st, {4'b0110, 16'h0}); end
    ready_i = 0;
    cyc();
    q_empty("bp");
  endtask
`ifdef SUBKEY_INJECT_ABORT_EN
  task automatic test_abort();
    start_i = 1; mode_i = 1; ready_i = 1; q.push_back(13);
    cyc(); start_i = 0;
    cyc(); abort_i = 1;
    checks++;
    if (word_idx_o !== 4'd14) begin errors++; $display("FAIL abort_pre got %0d exp 14", word_idx_o); end
    cyc(); abort_i = 0; ready_i = 0;
    checks++;
    if (st !== 20'h0) begin errors++; $display("FAIL abort_clear got %h exp 0", st); end
    cyc();
    checks++;
    if (st !== 20'h0) begin errors++; $display("FAIL abort_nodone got %h exp 0", st); end
    q_empty("abort");
  endtask
`endif
  initial begin
    test_reset();
    test_direct();
    test_err();
    test_sweep();
    test_backpressure();
`ifdef SUBKEY_INJECT_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
